gate_vector_checker: RTL



---
 rtl/gate_vector_checker_pkg.sv | 23 ++
 rtl/gate_vector_checker.sv | 104 ++++++++++
 2 files changed

// File: rtl/gate_vector_checker_pkg.sv
// Shared types and constants for the 2-input gate vector checker and lab gates.
package gate_vector_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int unsigned NUM_VECTORS = 4;
    localparam int unsigned VEC_W       = 2;
    localparam int unsigned ERR_W       = 3;
    localparam int unsigned CNT_W       = 4;

    // Truth tables: bit i is the expected y for input vector {a,b} == i.
    localparam logic [NUM_VECTORS-1:0] NAND_TT = 4'b0111;
    localparam logic [NUM_VECTORS-1:0] AND_TT  = 4'b1000;
    localparam logic [NUM_VECTORS-1:0] OR_TT   = 4'b1110;
    localparam logic [NUM_VECTORS-1:0] XOR_TT  = 4'b0110;
    localparam logic [NUM_VECTORS-1:0] NOR_TT  = 4'b0001;

endpackage

// File: rtl/gate_vector_checker.sv
// Walks all four {a,b} vectors into a gate under test, samples y after a settle
// interval against a truth table, and reports a mismatch count and pass verdict.
module gate_vector_checker
    import gate_vector_checker_pkg::*;
#(
    parameter int unsigned             SETTLE_CYCLES = 2,
    parameter logic [NUM_VECTORS-1:0]  EXPECTED      = NAND_TT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] vec_idx
);

    // A zero settle interval is treated as one clock.
    localparam int unsigned       SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam logic [CNT_W-1:0]  RELOAD     = CNT_W'(SETTLE_EFF - 1);
    localparam logic [VEC_W-1:0]  LAST_VEC   = VEC_W'(NUM_VECTORS - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [VEC_W-1:0] ab_q;
    logic [VEC_W-1:0] vec_q;
    logic [ERR_W-1:0] err_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic             mismatch_c;
    logic [ERR_W-1:0] err_next_c;

    // Error count including the vector being sampled this cycle (max 4, never wraps).
    assign mismatch_c = (y != EXPECTED[vec_q]);
    assign err_next_c = err_q + ERR_W'(mismatch_c);

    // Sequencer FSM: launch, settle, sample, and verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ab_q    <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        ab_q    <= '0;
                        vec_q   <= '0;
                        err_q   <= '0;
                        cnt_q   <= RELOAD;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    err_q <= err_next_c;
                    if (vec_q != LAST_VEC) begin
                        vec_q   <= vec_q + VEC_W'(1);
                        ab_q    <= vec_q + VEC_W'(1);
                        cnt_q   <= RELOAD;
                        state_q <= ST_SETTLE;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_next_c == ERR_W'(0));
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign a         = ab_q[1];
    assign b         = ab_q[0];
    assign vec_idx   = vec_q;
    assign err_count = err_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule
